// File: rtl/tt_lq_wb_ctrl.sv
// In-order load-queue tracker: allocates LQ ids, collects out-of-order return data
// and presents entries for writeback in allocation order. Optional macro: LQ_RET_BYPASS_EN.
package tt_lq_wb_ctrl_pkg;

    typedef struct packed {
        logic        load;
        logic        vec_load;
        logic        fp_load;
        logic        sign_ext;
        logic [1:0]  size;
        logic        rf_wren;
        logic        fp_wren;
        logic        vrf_wren;
        logic [4:0]  rf_wraddr;
        logic [31:0] pc;
        logic [28:0] vaddr;
    } lq_info_s;

endpackage

module tt_lq_wb_ctrl
    import tt_lq_wb_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ID_W   = $clog2(DEPTH),
    parameter int DATA_W = 256
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_alloc_vld,
    input  lq_info_s          i_alloc_info,
    output logic              o_alloc_rdy,
    output logic [ID_W-1:0]   o_alloc_id,
    input  logic              i_ret_vld,
    input  logic [ID_W-1:0]   i_ret_id,
    input  logic [DATA_W-1:0] i_ret_data,
    output logic              o_ret_err,
    output logic              o_wb_vld,
    input  logic              i_wb_rdy,
    output lq_info_s          o_wb_info,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [ID_W:0]     o_count,
    output logic              o_empty
);

    localparam int PTR_W = ID_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ID_W-1:0]   wr_idx;
    logic [ID_W-1:0]   rd_idx;
    logic              full;
    logic              alloc_fire;
    logic              alloc_no_data;
    logic              ret_legal;
    logic              head_ready;
    logic              byp_retire;
    logic              wb_fire;
    logic              ret_err_p1;

    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  ent_done;
    lq_info_s          ent_info [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    assign wr_idx        = wr_ptr[ID_W-1:0];
    assign rd_idx        = rd_ptr[ID_W-1:0];
    assign full          = (wr_idx == rd_idx) && (wr_ptr[ID_W] != rd_ptr[ID_W]);
    assign alloc_fire    = i_alloc_vld && !full;
    assign alloc_no_data = !i_alloc_info.load && !i_alloc_info.vec_load;
    // An id being allocated this cycle is not yet valid, so returning to it is illegal.
    assign ret_legal     = i_ret_vld && ent_vld[i_ret_id] && !ent_done[i_ret_id];
    assign head_ready    = ent_vld[rd_idx] && ent_done[rd_idx];

`ifdef LQ_RET_BYPASS_EN
    logic byp_hit;
    assign byp_hit    = ret_legal && (i_ret_id == rd_idx);
    assign o_wb_vld   = head_ready || byp_hit;
    assign o_wb_data  = byp_hit ? i_ret_data : ent_data[rd_idx];
    assign byp_retire = byp_hit && i_wb_rdy;
`else
    assign o_wb_vld   = head_ready;
    assign o_wb_data  = ent_data[rd_idx];
    assign byp_retire = 1'b0;
`endif

    assign o_wb_info   = ent_info[rd_idx];
    assign wb_fire     = o_wb_vld && i_wb_rdy;
    assign o_alloc_rdy = !full;
    assign o_alloc_id  = wr_idx;
    assign o_count     = wr_ptr - rd_ptr;
    assign o_empty     = (wr_ptr == rd_ptr);
    assign o_ret_err   = ret_err_p1;

    // Stage p1: entry state, pointers and the registered return-error pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ent_vld    <= '0;
            ent_done   <= '0;
            ret_err_p1 <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_data[i] <= '0;
            end
        end else begin
            ret_err_p1 <= i_ret_vld && !ret_legal;
            // Alloc only targets a free slot, so it never collides with retire or return.
            if (alloc_fire) begin
                ent_vld[wr_idx]  <= 1'b1;
                ent_done[wr_idx] <= alloc_no_data;
                if (alloc_no_data) begin
                    ent_data[wr_idx] <= '0;
                end
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ret_legal && !byp_retire) begin
                ent_done[i_ret_id] <= 1'b1;
                ent_data[i_ret_id] <= i_ret_data;
            end
            if (wb_fire) begin
                ent_vld[rd_idx]  <= 1'b0;
                ent_done[rd_idx] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (alloc_fire) begin
            ent_info[wr_idx] <= i_alloc_info;
        end
    end

endmodule

// File: tb/tb_tt_lq_wb_ctrl.sv
// Directed bench for tt_lq_wb_ctrl with an allocation-order scoreboard on the writeback port.
module tb_tt_lq_wb_ctrl;
    import tt_lq_wb_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_vld;
    lq_info_s     alloc_info;
    logic         o_alloc_rdy;
    logic [2:0]   o_alloc_id;
    logic         ret_vld;
    logic [2:0]   ret_id;
    logic [255:0] ret_data;
    logic         o_ret_err;
    logic         o_wb_vld;
    logic         wb_rdy;
    lq_info_s     o_wb_info;
    logic [255:0] o_wb_data;
    logic [3:0]   o_count;
    logic         o_empty;

    tt_lq_wb_ctrl #(.DEPTH(8), .ID_W(3), .DATA_W(256)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_alloc_vld (alloc_vld),
        .i_alloc_info(alloc_info),
        .o_alloc_rdy (o_alloc_rdy),
        .o_alloc_id  (o_alloc_id),
        .i_ret_vld   (ret_vld),
        .i_ret_id    (ret_id),
        .i_ret_data  (ret_data),
        .o_ret_err   (o_ret_err),
        .o_wb_vld    (o_wb_vld),
        .i_wb_rdy    (wb_rdy),
        .o_wb_info   (o_wb_info),
        .o_wb_data   (o_wb_data),
        .o_count     (o_count),
        .o_empty     (o_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       id;
        lq_info_s info;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] m_data [8];
    int           m_wr   = 0;
    int           serial = 0;
    int           total  = 0;
    int           bad    = 0;
    int           wb_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lq_info_s make_info(input logic ld, input logic [4:0] wa);
        lq_info_s inf;
        inf           = '0;
        inf.load      = ld;
        inf.rf_wren   = 1'b1;
        inf.rf_wraddr = wa;
        inf.pc        = 32'h1000 + 32'(serial);
        inf.vaddr     = 29'(serial * 3 + 1);
        return inf;
    endfunction

    task automatic do_alloc(input logic ld, input logic [4:0] wa);
        lq_info_s inf;
        exp_t     e;
        inf = make_info(ld, wa);
        serial++;
        alloc_vld  = 1'b1;
        alloc_info = inf;
        #1;
        chk("alloc_rdy", o_alloc_rdy, 1'b1);
        chk("alloc_id", o_alloc_id, m_wr[2:0]);
        e.id   = m_wr % 8;
        e.info = inf;
        exp_q.push_back(e);
        if (!ld) m_data[e.id] = '0;
        m_wr++;
        tick();
        alloc_vld = 1'b0;
    endtask

    task automatic do_ret(input int id, input logic [255:0] d, input logic legal);
        ret_vld  = 1'b1;
        ret_id   = id[2:0];
        ret_data = d;
        if (legal) m_data[id] = d;
        tick();
        ret_vld = 1'b0;
        chk("ret_err", o_ret_err, !legal);
    endtask

    // Scoreboard: every accepted writeback must match the oldest outstanding allocation.
    always @(negedge clk) begin
        if (o_wb_vld && wb_rdy) begin
            wb_cnt++;
            if (exp_q.size() == 0) begin
                chk("wb_spurious", o_wb_vld, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_info", o_wb_info, e.info);
                chk("wb_data", o_wb_data, m_data[e.id]);
            end
        end
    end

    initial begin
        int       base;
        int       id;
        lq_info_s inf;
        rst_n      = 1'b0;
        alloc_vld  = 1'b0;
        alloc_info = '0;
        ret_vld    = 1'b0;
        ret_id     = '0;
        ret_data   = '0;
        wb_rdy     = 1'b0;
        for (int i = 0; i < 8; i++) m_data[i] = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_count", o_count, 4'd0);
        chk("rst_alloc_rdy", o_alloc_rdy, 1'b1);
        chk("rst_wb_vld", o_wb_vld, 1'b0);
        chk("rst_ret_err", o_ret_err, 1'b0);
        chk("rst_alloc_id", o_alloc_id, 3'd0);
        rst_n = 1'b1;
        tick();

        // Fill and drain with out-of-order returns
        wb_rdy = 1'b1;
        for (int i = 0; i < 8; i++) do_alloc(1'b1, 5'(i + 1));
        chk("full_alloc_rdy", o_alloc_rdy, 1'b0);
        chk("full_count", o_count, 4'd8);
        do_ret(5, 256'h5555_0005, 1'b1);
        chk("ooo5_wb_vld", o_wb_vld, 1'b0);
        do_ret(2, 256'h2222_0002, 1'b1);
        chk("ooo2_wb_vld", o_wb_vld, 1'b0);
        do_ret(0, {8{32'hA0A0_0000}}, 1'b1);
        chk("head0_wb_vld", o_wb_vld, 1'b1);
        chk("head0_first", wb_cnt, 0);
        do_ret(1, 256'h1111_0001, 1'b1);
        do_ret(3, 256'h3333_0003, 1'b1);
        do_ret(4, 256'h4444_0004, 1'b1);
        do_ret(6, 256'h6666_0006, 1'b1);
        do_ret(7, 256'h7777_0007, 1'b1);
        repeat (8) tick();
        chk("drain_cnt", wb_cnt, 8);
        chk("drain_empty", o_empty, 1'b1);
        chk("drain_count", o_count, 4'd0);

        // Non-load alloc retires without data
        wb_rdy = 1'b0;
        do_alloc(1'b0, 5'd5);
        chk("nl_wb_vld", o_wb_vld, 1'b1);
        chk("nl_wb_data", o_wb_data, 256'd0);
        chk("nl_rf_wraddr", o_wb_info.rf_wraddr, 5'd5);
        wb_rdy = 1'b1;
        tick();
        wb_rdy = 1'b0;

        // Backpressure holds the head stable
        id = m_wr % 8;
        do_alloc(1'b1, 5'd7);
        do_ret(id, {4{64'hDEAD_BEEF_0BAD_F00D}}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_wb_vld", o_wb_vld, 1'b1);
            chk("bp_wb_data", o_wb_data, {4{64'hDEAD_BEEF_0BAD_F00D}});
            tick();
        end
        base   = wb_cnt;
        wb_rdy = 1'b1;
        tick();
        chk("bp_retire_cnt", wb_cnt, base + 1);
        chk("bp_retire_empty", o_empty, 1'b1);

        // Illegal return to an empty slot
        do_ret(5, 256'hBAD, 1'b0);
        tick();
        chk("err_pulse_empty", o_ret_err, 1'b0);
        chk("err_empty_count", o_count, 4'd0);

        // Illegal return to an already-done id 2
        wb_rdy = 1'b0;
        id = m_wr % 8;
        do_alloc(1'b1, 5'd9);
        do_ret(id, 256'hC0FFEE_02, 1'b1);
        do_ret(id, 256'hBADBAD_02, 1'b0);
        tick();
        chk("err_pulse_done", o_ret_err, 1'b0);
        chk("err_done_id", id, 2);
        chk("err_done_data", o_wb_data, 256'hC0FFEE_02);
        chk("err_done_count", o_count, 4'd1);
        wb_rdy = 1'b1;
        repeat (2) tick();
        chk("err_done_empty", o_empty, 1'b1);

        // Asynchronous reset mid-operation
        wb_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_alloc(1'b1, 5'(i + 20));
        do_ret(m_wr % 8 == 0 ? 3 : (m_wr - 4) % 8, 256'h77, 1'b1);
        do_ret((m_wr + 2) % 8, 256'h88, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_wb_vld", o_wb_vld, 1'b0);
        chk("arst_count", o_count, 4'd0);
        chk("arst_empty", o_empty, 1'b1);
        chk("arst_alloc_rdy", o_alloc_rdy, 1'b1);
        chk("arst_alloc_id", o_alloc_id, 3'd0);
        chk("arst_ret_err", o_ret_err, 1'b0);
        exp_q.delete();
        m_wr = 0;
        tick();
        rst_n  = 1'b1;
        wb_rdy = 1'b1;
        base   = wb_cnt;
        repeat (5) tick();
        chk("arst_no_wb", wb_cnt, base);
        chk("arst_idle_vld", o_wb_vld, 1'b0);

        // Full with head done: no alloc while full, even when the head retires
        wb_rdy = 1'b0;
        for (int i = 0; i < 8; i++) do_alloc(1'b1, 5'(i + 10));
        do_ret(0, 256'hF00, 1'b1);
        inf = make_info(1'b1, 5'd30);
        serial++;
        alloc_vld  = 1'b1;
        alloc_info = inf;
        wb_rdy     = 1'b1;
        #1;
        chk("fullret_alloc_rdy", o_alloc_rdy, 1'b0);
        tick();
        chk("fullret_count", o_count, 4'd7);
        chk("fullret_rdy_after", o_alloc_rdy, 1'b1);
        chk("fullret_wrap_id", o_alloc_id, 3'd0);
        begin
            exp_t e;
            e.id   = m_wr % 8;
            e.info = inf;
            exp_q.push_back(e);
            m_wr++;
        end
        tick();
        alloc_vld = 1'b0;
        chk("fullret_refill_count", o_count, 4'd8);
        base = wb_cnt;
        for (int i = 1; i < 8; i++) do_ret(i, 256'(i * 16 + 1), 1'b1);
        do_ret(0, 256'hABCD, 1'b1);
        repeat (4) tick();
        chk("fullret_drain_cnt", wb_cnt, base + 8);
        chk("fullret_empty", o_empty, 1'b1);

        // Return to head: same-cycle bypass or one-cycle latency
        wb_rdy = 1'b1;
        id = m_wr % 8;
        do_alloc(1'b1, 5'd3);
        ret_vld  = 1'b1;
        ret_id   = id[2:0];
        ret_data = 256'h1234_5678_9ABC;
        m_data[id] = 256'h1234_5678_9ABC;
        #1;
`ifdef LQ_RET_BYPASS_EN
        chk("byp_wb_vld", o_wb_vld, 1'b1);
        chk("byp_wb_data", o_wb_data, 256'h1234_5678_9ABC);
        chk("byp_count_before", o_count, 4'd1);
        tick();
        ret_vld = 1'b0;
        chk("byp_count_after", o_count, 4'd0);
`else
        chk("lat_same_cycle_vld", o_wb_vld, 1'b0);
        tick();
        ret_vld = 1'b0;
        chk("lat_next_cycle_vld", o_wb_vld, 1'b1);
        tick();
        chk("lat_count_after", o_count, 4'd0);
`endif
        repeat (2) tick();
        chk("final_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
